// File: rtl/universal_dreg.sv
// Parametrised D register with hold/load/shift/rotate/count modes and async clear.
// Define UREG_ASYNC_PRESET_EN to add the asynchronous active-low preset input Sbar.
module universal_dreg #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
    input  logic             Cp,
    input  logic             Rbar,
`ifdef UREG_ASYNC_PRESET_EN
    input  logic             Sbar,
`endif
    input  logic [2:0]       Mode,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    input  logic             Sr,
    input  logic             Sl,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             Tc
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_UP   = 3'b110;
    localparam logic [2:0] MODE_DOWN = 3'b111;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (En) begin
            unique case (Mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = D;
                MODE_SHR:  q_d = {Sr, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], Sl};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_UP:   q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
                MODE_DOWN: q_d = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
                default:   q_d = q_q;
            endcase
        end
    end

`ifdef UREG_ASYNC_PRESET_EN
    // Clear dominates preset, so Q and Qbar can never be equal.
    always_ff @(posedge Cp or negedge Rbar or negedge Sbar) begin
        if (!Rbar) begin
            q_q <= RESET_VALUE;
        end else if (!Sbar) begin
            q_q <= PRESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end
`else
    always_ff @(posedge Cp or negedge Rbar) begin
        if (!Rbar) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    logic unused_preset;
    assign unused_preset = ^PRESET_VALUE;
`endif

    assign Q    = q_q;
    assign Qbar = ~q_q;

    // Terminal count ignores En so stages can cascade as En_next = Tc & En.
    always_comb begin
        Tc = 1'b0;
        if (Mode == MODE_UP && q_q == {WIDTH{1'b1}}) begin
            Tc = 1'b1;
        end else if (Mode == MODE_DOWN && q_q == {WIDTH{1'b0}}) begin
            Tc = 1'b1;
        end
    end

endmodule

// File: tb/tb_universal_dreg.sv
// Self-checking bench for universal_dreg (WIDTH=8): arithmetic reference model plus
// directed vectors with literal expectations.
module tb_universal_dreg;

    logic       Cp;
    logic       Rbar;
    logic [2:0] Mode;
    logic       En;
    logic [7:0] D;
    logic       Sr;
    logic       Sl;
    logic [7:0] Q;
    logic [7:0] Qbar;
    logic       Tc;
`ifdef UREG_ASYNC_PRESET_EN
    logic       Sbar;
`endif

    int checks = 0;
    int errors = 0;

    universal_dreg #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00),
        .PRESET_VALUE(8'hFF)
    ) dut (
        .Cp  (Cp),
        .Rbar(Rbar),
`ifdef UREG_ASYNC_PRESET_EN
        .Sbar(Sbar),
`endif
        .Mode(Mode),
        .En  (En),
        .D   (D),
        .Sr  (Sr),
        .Sl  (Sl),
        .Q   (Q),
        .Qbar(Qbar),
        .Tc  (Tc)
    );

    initial begin
        Cp = 1'b0;
        forever #25 Cp = ~Cp;
    end

    // Reference next value computed with plain integer arithmetic.
    function automatic logic [7:0] model_next(input logic [2:0] m, input logic [7:0] q,
                                              input logic [7:0] d, input logic sr,
                                              input logic sl);
        int v;
        int r;
        v = int'(q);
        case (m)
            3'd0:    r = v;
            3'd1:    r = int'(d);
            3'd2:    r = v / 2 + int'(sr) * 128;
            3'd3:    r = (v * 2) % 256 + int'(sl);
            3'd4:    r = v / 2 + (v % 2) * 128;
            3'd5:    r = (v * 2) % 256 + v / 128;
            3'd6:    r = (v + 1) % 256;
            default: r = (v + 255) % 256;
        endcase
        return r[7:0];
    endfunction

    logic [7:0] mq;

`ifdef UREG_ASYNC_PRESET_EN
    always @(posedge Cp or negedge Rbar or negedge Sbar) begin
        if (!Rbar)      mq <= 8'h00;
        else if (!Sbar) mq <= 8'hFF;
        else if (En)    mq <= model_next(Mode, mq, D, Sr, Sl);
    end
`else
    always @(posedge Cp or negedge Rbar) begin
        if (!Rbar)    mq <= 8'h00;
        else if (En)  mq <= model_next(Mode, mq, D, Sr, Sl);
    end
`endif

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge, away from the active edge.
    always @(negedge Cp) begin
        logic exp_tc;
        exp_tc = (Mode == 3'd6 && mq == 8'd255) || (Mode == 3'd7 && mq == 8'd0);
        check("model_q", Q, mq);
        check("model_qbar", Qbar, 8'hFF - mq);
        check("model_tc", {7'd0, Tc}, {7'd0, exp_tc});
    end

    task automatic step();
        @(posedge Cp);
        #1;
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp[0] = 8'h0F; sweep_exp[1] = 8'h33; sweep_exp[2] = 8'h99; sweep_exp[3] = 8'h32;
        sweep_exp[4] = 8'h19; sweep_exp[5] = 8'h32; sweep_exp[6] = 8'h33; sweep_exp[7] = 8'h32;

        Rbar = 1'b0; En = 1'b0; Mode = 3'd0; D = 8'h00; Sr = 1'b0; Sl = 1'b0;
`ifdef UREG_ASYNC_PRESET_EN
        Sbar = 1'b1;
`endif
        #1;
        check("reset_q", Q, 8'h00);
        check("reset_qbar", Qbar, 8'hFF);
        check("reset_tc", {7'd0, Tc}, 8'h00);
        step();
        Rbar = 1'b1;

        // Async clear mid-cycle, then held across edges
        Mode = 3'd1; D = 8'hA5; En = 1'b1;
        step();
        check("load_a5", Q, 8'hA5);
        #29;
        Rbar = 1'b0;
        #1;
        check("async_clr_q", Q, 8'h00);
        check("async_clr_qbar", Qbar, 8'hFF);
        D = 8'h3C;
        step();
        step();
        check("clr_held", Q, 8'h00);
        Rbar = 1'b1;

        // Load and enable
        D = 8'h5A;
        step();
        check("load_5a", Q, 8'h5A);
        D = 8'hFF; En = 1'b0;
        step();
        check("en_hold", Q, 8'h5A);
        En = 1'b1;

        // Shift and rotate
        D = 8'h81;
        step();
        Mode = 3'd2; Sr = 1'b0;
        step();
        check("shr", Q, 8'h40);
        Mode = 3'd3; Sl = 1'b1;
        step();
        check("shl", Q, 8'h81);
        Mode = 3'd4;
        step();
        check("ror", Q, 8'hC0);
        Mode = 3'd5;
        step();
        check("rol", Q, 8'h81);

        // Count wrap and terminal count
        Mode = 3'd1; D = 8'hFE;
        step();
        Mode = 3'd6;
        #1;
        check("tc_up_fe", {7'd0, Tc}, 8'h00);
        step();
        check("up_ff", Q, 8'hFF);
        check("tc_up_ff", {7'd0, Tc}, 8'h01);
        step();
        check("up_wrap", Q, 8'h00);
        Mode = 3'd7;
        #1;
        check("tc_down_00", {7'd0, Tc}, 8'h01);
        step();
        check("down_wrap", Q, 8'hFF);

        // Tc is not gated by En
        Mode = 3'd1; D = 8'h00;
        step();
        En = 1'b0; Mode = 3'd7;
        #1;
        check("tc_ungated", {7'd0, Tc}, 8'h01);
        step();
        check("down_disabled", Q, 8'h00);
        En = 1'b1;

`ifdef UREG_ASYNC_PRESET_EN
        Sbar = 1'b0;
        #1;
        check("preset_q", Q, 8'hFF);
        Rbar = 1'b0;
        #1;
        check("clr_wins_q", Q, 8'h00);
        check("clr_wins_qbar", Qbar, 8'hFF);
        step();
        Mode = 3'd6; Sbar = 1'b1; Rbar = 1'b1;
        step();
        check("post_release_up", Q, 8'h01);
`endif

        // Mode sweep
        Mode = 3'd1; D = 8'h0F;
        step();
        D = 8'h33; Sr = 1'b1; Sl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Mode = 3'(i);
            step();
            check($sformatf("sweep_mode%0d", i), Q, sweep_exp[i]);
        end

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
